// File: rtl/discharge_pulse_if.sv
// Bundle between the EDM pulse sequencer and its environment. The environment
// side carries the mode word, durations, the detector flag and the single-shot button.
`timescale 1ns/1ps
interface discharge_pulse_if;
  logic [15:0] waveform;
  logic [15:0] ton_cycles;
  logic [15:0] toff_cycles;
  logic        is_breakdown;
  logic        signle_discharge_button_pressed;
  logic [7:0]  current_state;
  logic [31:0] timer_wait_breakdown;
  logic        gate_buck;
  logic        gate_res;
  logic        discharge_done;
  logic        no_breakdown;
  logic [15:0] pulse_count;

  modport master (
    output waveform, ton_cycles, toff_cycles, is_breakdown, signle_discharge_button_pressed,
    input  current_state, timer_wait_breakdown, gate_buck, gate_res,
           discharge_done, no_breakdown, pulse_count
  );

  modport slave (
    input  waveform, ton_cycles, toff_cycles, is_breakdown, signle_discharge_button_pressed,
    output current_state, timer_wait_breakdown, gate_buck, gate_res,
           discharge_done, no_breakdown, pulse_count
  );
endinterface

// File: rtl/discharge_pulse_fsm.sv
// Pulse sequencer for one EDM discharge channel: idle -> open-voltage wait ->
// buck/resistor discharge for Ton -> deionisation for Toff, with registered gate enables.
`timescale 1ns/1ps
module discharge_pulse_fsm #(
  parameter logic [31:0] BLANK_TIME   = 32'd300,
  parameter logic [31:0] WAIT_TIMEOUT = 32'd100000
) (
  input  logic              clk,
  input  logic              rst_n,
  discharge_pulse_if.slave  bus
);

  typedef enum logic [7:0] {
    S_IDLE            = 8'h00,
    S_WAIT_BREAKDOWN  = 8'h01,
    S_BUCK_INTERLEAVE = 8'h02,
    S_RES_DISCHARGE   = 8'h04,
    S_DEION           = 8'h80
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  mode_q, mode_d;        // [1] buck path, [0] single-shot
  logic [31:0] timer_q, timer_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] dur_q, dur_d;
  logic [15:0] pulse_count_q, pulse_count_d;
  logic        gate_buck_q, gate_buck_d;
  logic        gate_res_q, gate_res_d;
  logic        done_q, done_d;
  logic        nb_q, nb_d;
  logic        open_w;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] min_one16(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

  assign open_w = bus.waveform[13];

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    cnt_d         = cnt_q;
    dur_d         = dur_q;
    pulse_count_d = pulse_count_q;
    done_d        = 1'b0;
    nb_d          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (open_w && (!bus.waveform[14] || bus.signle_discharge_button_pressed)) begin
          state_d = S_WAIT_BREAKDOWN;
          mode_d  = bus.waveform[15:14];
        end
      end
      S_WAIT_BREAKDOWN: begin
        if (bus.is_breakdown && (timer_q > BLANK_TIME)) begin
          state_d = mode_q[1] ? S_BUCK_INTERLEAVE : S_RES_DISCHARGE;
        end else if (timer_q == WAIT_TIMEOUT - 32'd1) begin
          state_d = S_DEION;
          nb_d    = 1'b1;
        end else if (!open_w) begin
          state_d = S_DEION;
        end
      end
      S_BUCK_INTERLEAVE, S_RES_DISCHARGE: begin
        cnt_d = cnt_q + 16'd1;
        if (!open_w) begin
          state_d = S_DEION;
        end else if (cnt_q == dur_q - 16'd1) begin
          done_d        = 1'b1;
          pulse_count_d = pulse_count_q + 16'd1;
          // Single-shot skips Toff; the detector clears its flag while idle.
          state_d       = mode_q[0] ? S_IDLE : S_DEION;
        end
      end
      S_DEION: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == dur_q - 16'd1) begin
          if (open_w && !mode_q[0]) begin
            state_d = S_WAIT_BREAKDOWN;
            mode_d  = bus.waveform[15:14];
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Durations are captured on entry so mid-phase edits do not stretch a pulse.
    if (state_d != state_q) begin
      cnt_d = 16'd0;
      if (state_d == S_BUCK_INTERLEAVE || state_d == S_RES_DISCHARGE) begin
        dur_d = min_one16(bus.ton_cycles);
      end else if (state_d == S_DEION) begin
        dur_d = min_one16(bus.toff_cycles);
      end
    end

    timer_d = (state_q == S_WAIT_BREAKDOWN && state_d == S_WAIT_BREAKDOWN)
              ? sat_inc32(timer_q) : 32'd0;

    gate_buck_d = (state_d == S_WAIT_BREAKDOWN && mode_d[1]) || (state_d == S_BUCK_INTERLEAVE);
    gate_res_d  = (state_d == S_WAIT_BREAKDOWN && !mode_d[1]) || (state_d == S_RES_DISCHARGE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      mode_q        <= 2'b00;
      timer_q       <= 32'd0;
      cnt_q         <= 16'd0;
      dur_q         <= 16'd0;
      pulse_count_q <= 16'd0;
      gate_buck_q   <= 1'b0;
      gate_res_q    <= 1'b0;
      done_q        <= 1'b0;
      nb_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      timer_q       <= timer_d;
      cnt_q         <= cnt_d;
      dur_q         <= dur_d;
      pulse_count_q <= pulse_count_d;
      gate_buck_q   <= gate_buck_d;
      gate_res_q    <= gate_res_d;
      done_q        <= done_d;
      nb_q          <= nb_d;
    end
  end

  assign bus.current_state        = state_q;
  assign bus.timer_wait_breakdown = timer_q;
  assign bus.gate_buck            = gate_buck_q;
  assign bus.gate_res             = gate_res_q;
  assign bus.discharge_done       = done_q;
  assign bus.no_breakdown         = nb_q;
  assign bus.pulse_count          = pulse_count_q;

endmodule

// File: tb/tb_discharge_pulse_fsm.sv
// Bench for discharge_pulse_fsm: table of pulse scenarios checked through a
// state-segment scoreboard, plus hand-written single-shot, mode-latch and reset sequences.
`timescale 1ns/1ps
module tb_discharge_pulse_fsm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  discharge_pulse_if bus();

  discharge_pulse_fsm #(.BLANK_TIME(32'd300), .WAIT_TIMEOUT(32'd1000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] st;
    int         len;   // -1: length not checked
    logic [7:0] nxt;
  } seg_t;

  typedef struct {
    logic [15:0] wf;
    logic [15:0] ton;
    logic [15:0] toff;
    int          bd_at;     // -1 none, -2 held from WAIT entry, else wait-timer value
    int          abort_at;  // discharge cycle on which bit13 is cleared, -1 none
    int          nseg;
    seg_t        s0, s1, s2;
    int          n_done;
    int          n_nb;
    logic [15:0] cnt;
  } row_t;

  seg_t sb[$];
  row_t rows [8];

  int         nchk = 0;
  int         nbad = 0;
  int         n_done, n_nb, seg_len;
  logic [7:0] prev_st;
  bit         gate_chk;
  logic       exp_buck;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    nchk++;
    nbad++;
    $display("FAIL %s: wait bound expired, got state %0h", nm, bus.current_state);
  endtask

  task automatic mon();
    seg_t e;
    logic eb, er;
    if (!rst_n) begin
      prev_st = 8'h00;
      seg_len = 0;
      return;
    end
    if (bus.discharge_done) n_done++;
    if (bus.no_breakdown) n_nb++;
    if (gate_chk) begin
      eb = 1'b0;
      er = 1'b0;
      case (bus.current_state)
        8'h01: begin eb = exp_buck; er = !exp_buck; end
        8'h02: eb = 1'b1;
        8'h04: er = 1'b1;
        default: ;
      endcase
      check("gate_buck", bus.gate_buck, eb);
      check("gate_res", bus.gate_res, er);
      if (bus.current_state != 8'h01) check("timer_outside_wait", bus.timer_wait_breakdown, 0);
    end
    if (bus.current_state != prev_st) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("seg_state", prev_st, e.st);
        if (e.len >= 0) check("seg_len", seg_len, e.len);
        check("seg_next", bus.current_state, e.nxt);
      end
      if (bus.current_state == 8'h01) check("wait_timer_start", bus.timer_wait_breakdown, 0);
      prev_st = bus.current_state;
      seg_len = 1;
    end else begin
      seg_len++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.waveform = 16'h0000;
    bus.is_breakdown = 1'b0;
    bus.signle_discharge_button_pressed = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_state(input logic [7:0] st, input string nm);
    int n = 0;
    while (bus.current_state != st && n < 3000) begin tick(); n++; end
    if (bus.current_state != st) timeout_fail(nm);
  endtask

  task automatic wait_leave(input logic [7:0] st, input string nm);
    int n = 0;
    while (bus.current_state == st && n < 3000) begin tick(); n++; end
    if (bus.current_state == st) timeout_fail(nm);
  endtask

  task automatic wait_timer(input logic [31:0] v, input string nm);
    int n = 0;
    while (!(bus.current_state == 8'h01 && bus.timer_wait_breakdown == v) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) timeout_fail(nm);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sb.size() > 0 && n < 3000) begin tick(); n++; end
    if (sb.size() > 0) begin
      timeout_fail(nm);
      sb.delete();
    end
  endtask

  task automatic run_row(input row_t r, input int idx);
    do_reset();
    gate_chk = 1'b1;
    exp_buck = r.wf[15];
    n_done = 0;
    n_nb = 0;
    bus.ton_cycles = r.ton;
    bus.toff_cycles = r.toff;
    bus.is_breakdown = (r.bd_at == -2);
    sb.push_back('{8'h00, -1, 8'h01});
    sb.push_back(r.s0);
    if (r.nseg > 1) sb.push_back(r.s1);
    if (r.nseg > 2) sb.push_back(r.s2);
    bus.waveform = r.wf;
    if (r.wf[14]) begin
      tick();
      bus.signle_discharge_button_pressed = 1'b1;
      tick();
      bus.signle_discharge_button_pressed = 1'b0;
    end
    wait_state(8'h01, $sformatf("row%0d_enter_wait", idx));
    if (r.bd_at >= 0) begin
      wait_timer(r.bd_at, $sformatf("row%0d_timer", idx));
      bus.is_breakdown = 1'b1;
    end
    if (r.bd_at != -1) begin
      wait_leave(8'h01, $sformatf("row%0d_leave_wait", idx));
      bus.is_breakdown = 1'b0;
    end
    if (r.abort_at > 0) begin
      repeat (r.abort_at - 1) tick();
      bus.waveform = r.wf & ~16'h2000;
    end
    drain($sformatf("row%0d_drain", idx));
    check($sformatf("row%0d_done_pulses", idx), n_done, r.n_done);
    check($sformatf("row%0d_nb_pulses", idx), n_nb, r.n_nb);
    check($sformatf("row%0d_pulse_count", idx), bus.pulse_count, r.cnt);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.waveform = 16'h0000;
    bus.ton_cycles = 16'd0;
    bus.toff_cycles = 16'd0;
    bus.is_breakdown = 1'b0;
    bus.signle_discharge_button_pressed = 1'b0;
    gate_chk = 1'b0;
    exp_buck = 1'b0;
    prev_st = 8'h00;
    seg_len = 0;
    n_done = 0;
    n_nb = 0;

    //          wf        ton     toff    bd    abort nseg  s0                  s1                 s2                 done nb cnt
    rows[0] = '{16'hA000, 16'd50, 16'd100, 400, -1, 3, '{8'h01, 401, 8'h02}, '{8'h02, 50, 8'h80}, '{8'h80, 100, 8'h01}, 1, 0, 16'd1};
    rows[1] = '{16'hA000, 16'd5,  16'd3,   -2,  -1, 3, '{8'h01, 302, 8'h02}, '{8'h02, 5, 8'h80},  '{8'h80, 3, 8'h01},   1, 0, 16'd1};
    rows[2] = '{16'h2000, 16'd0,  16'd10,  -1,  -1, 2, '{8'h01, 1000, 8'h80}, '{8'h80, 10, 8'h01}, '{8'h00, 0, 8'h00},  0, 1, 16'd0};
    rows[3] = '{16'h2000, 16'd4,  16'd6,   999, -1, 3, '{8'h01, 1000, 8'h04}, '{8'h04, 4, 8'h80},  '{8'h80, 6, 8'h01},   1, 0, 16'd1};
    rows[4] = '{16'hA000, 16'd0,  16'd0,   310, -1, 3, '{8'h01, 311, 8'h02}, '{8'h02, 1, 8'h80},  '{8'h80, 1, 8'h01},   1, 0, 16'd1};
    rows[5] = '{16'hA000, 16'd50, 16'd5,   305, 10, 3, '{8'h01, 306, 8'h02}, '{8'h02, 10, 8'h80}, '{8'h80, 5, 8'h00},   0, 0, 16'd0};
    rows[6] = '{16'h2000, 16'd3,  16'd2,   301, -1, 3, '{8'h01, 302, 8'h04}, '{8'h04, 3, 8'h80},  '{8'h80, 2, 8'h01},   1, 0, 16'd1};
    rows[7] = '{16'h6000, 16'd20, 16'd7,   350, -1, 2, '{8'h01, 351, 8'h04}, '{8'h04, 20, 8'h00}, '{8'h00, 0, 8'h00},   1, 0, 16'd1};

    // Reset values
    do_reset();
    check("rst_state", bus.current_state, 8'h00);
    check("rst_timer", bus.timer_wait_breakdown, 0);
    check("rst_gate_buck", bus.gate_buck, 0);
    check("rst_gate_res", bus.gate_res, 0);
    check("rst_done", bus.discharge_done, 0);
    check("rst_nb", bus.no_breakdown, 0);
    check("rst_pulse_count", bus.pulse_count, 0);

    for (int i = 0; i < 8; i++) run_row(rows[i], i);

    // Single-shot stays idle without a button, ignores a press while closed, restarts on a press
    repeat (20) tick();
    check("single_idle_hold", bus.current_state, 8'h00);
    bus.waveform = 16'h4000;
    tick();
    bus.signle_discharge_button_pressed = 1'b1;
    tick();
    bus.signle_discharge_button_pressed = 1'b0;
    bus.waveform = 16'h6000;
    repeat (5) tick();
    check("single_press_discarded", bus.current_state, 8'h00);
    bus.signle_discharge_button_pressed = 1'b1;
    tick();
    bus.signle_discharge_button_pressed = 1'b0;
    check("single_restart_state", bus.current_state, 8'h01);
    check("single_restart_gate_res", bus.gate_res, 1);

    // Mode bits changed mid-pulse take effect only at the next WAIT entry
    do_reset();
    gate_chk = 1'b0;
    bus.ton_cycles = 16'd2;
    bus.toff_cycles = 16'd2;
    sb.push_back('{8'h00, -1, 8'h01});
    sb.push_back('{8'h01, 321, 8'h02});
    sb.push_back('{8'h02, 2, 8'h80});
    sb.push_back('{8'h80, 2, 8'h01});
    bus.waveform = 16'hA000;
    wait_state(8'h01, "latch_enter_wait");
    bus.waveform = 16'h2000;
    wait_timer(320, "latch_timer");
    bus.is_breakdown = 1'b1;
    wait_leave(8'h01, "latch_leave_wait");
    bus.is_breakdown = 1'b0;
    drain("latch_drain");
    check("relatch_gate_res", bus.gate_res, 1);
    check("relatch_gate_buck", bus.gate_buck, 0);

    // Asynchronous reset in the middle of a buck discharge
    do_reset();
    gate_chk = 1'b1;
    exp_buck = 1'b1;
    bus.ton_cycles = 16'd50;
    bus.toff_cycles = 16'd5;
    bus.waveform = 16'hA000;
    wait_state(8'h01, "arst_enter_wait");
    wait_timer(305, "arst_timer");
    bus.is_breakdown = 1'b1;
    wait_leave(8'h01, "arst_leave_wait");
    bus.is_breakdown = 1'b0;
    repeat (5) tick();
    check("arst_pre_state", bus.current_state, 8'h02);
    check("arst_pre_gate", bus.gate_buck, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_state", bus.current_state, 8'h00);
    check("arst_gate_buck", bus.gate_buck, 0);
    check("arst_gate_res", bus.gate_res, 0);
    check("arst_timer", bus.timer_wait_breakdown, 0);
    check("arst_done", bus.discharge_done, 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("arst_release_state", bus.current_state, 8'h00);
    check("arst_release_timer", bus.timer_wait_breakdown, 0);
    tick();
    check("arst_rewait_state", bus.current_state, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nbad);
    $finish;
  end

endmodule

// File: doc/discharge_pulse_fsm.md
Name: discharge_pulse_fsm

Overview:
- Top-level pulse sequencer for one EDM discharge channel. Sits directly downstream of the breakdown detector and consumes its is_breakdown flag.
- Produces the current_state and timer_wait_breakdown that the detector uses, plus the MOSFET gate enables.
- Sequences each pulse: idle → open-voltage wait → discharge (buck or resistor) for Ton → deionisation for Toff.
- Supports continuous and single-shot modes, and aborts to deionisation on breakdown timeout.

Parameters:
- BLANK_TIME, 32'd300: wait-state cycles during which is_breakdown is ignored (voltage rise slope).
- WAIT_TIMEOUT, 32'd100000: wait-state cycles with no breakdown before the pulse is abandoned (1 ms at 100 MHz).

Ports:
- clk  in  1  100 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- waveform  in  16  mode word: bit15 1=buck / 0=resistor; bit14 1=single / 0=continuous; bit13 1=machining open / 0=closed
- ton_cycles  in  16  discharge duration in clk cycles
- toff_cycles  in  16  deionisation duration in clk cycles
- is_breakdown  in  1  registered breakdown flag from the detector
- signle_discharge_button_pressed  in  1  one-cycle single-shot trigger
- current_state  out  8  one-hot-style state code
- timer_wait_breakdown  out  32  cycles spent in the current wait state
- gate_buck  out  1  buck path MOSFET enable
- gate_res  out  1  resistor path MOSFET enable
- discharge_done  out  1  one-cycle pulse at the end of every discharge
- no_breakdown  out  1  one-cycle pulse on wait timeout
- pulse_count  out  16  completed discharges, wraps at 16'hFFFF→0

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous, active-low on rst_n. Reset values:
  - current_state = S_IDLE (8'h00)
  - all timers/counters = 0
  - gate_buck = gate_res = 0
  - discharge_done = no_breakdown = 0
- State codes (must match the detector exactly): S_IDLE 8'h00 (same code as S_DEION_SINGLE_BUCK), S_WAIT_BREAKDOWN 8'h01, S_BUCK_INTERLEAVE 8'h02, S_RES_DISCHARGE 8'h04, S_DEION 8'h80.
- Mode latch: waveform[15:14] is latched on every IDLE→WAIT or DEION→WAIT transition. Changes to those bits mid-pulse have no effect. waveform[13] is sampled live.
- S_IDLE:
  - bit13=0 → stay.
  - bit13=1 and continuous → WAIT next cycle.
  - bit13=1 and single → WAIT on the cycle after the button pulse. A button press while bit13=0 is discarded.
- S_WAIT_BREAKDOWN:
  - timer_wait_breakdown is 0 on the first cycle, +1 per cycle, saturates at 32'hFFFFFFFF. It is 0 in all other states.
  - is_breakdown=1 with timer > BLANK_TIME → S_BUCK_INTERLEAVE if latched bit15=1, else S_RES_DISCHARGE.
  - Else timer == WAIT_TIMEOUT-1 → S_DEION, no_breakdown=1 for one cycle.
  - Breakdown and timeout in the same cycle: breakdown wins.
  - bit13 cleared → S_DEION.
- S_BUCK_INTERLEAVE / S_RES_DISCHARGE:
  - On-counter counts 0..max(ton_cycles,1)-1. On the last count: discharge_done=1, pulse_count+1.
  - Next state: S_DEION if continuous; S_IDLE if single (no Toff; the detector clears is_breakdown in S_IDLE).
  - bit13 cleared during discharge → S_DEION immediately; no done pulse, no count.
- S_DEION:
  - Off-counter counts 0..max(toff_cycles,1)-1, then: WAIT if bit13=1 and latched mode is continuous, else S_IDLE.
  - Minimum 1 cycle guarantees the detector has cleared is_breakdown before WAIT is re-entered.
- ton_cycles/toff_cycles are sampled on state entry.
- Gates are registered and change on the same edge as current_state:
  - gate_buck = (WAIT && latched bit15) || BUCK_INTERLEAVE
  - gate_res = (WAIT && !latched bit15) || RES_DISCHARGE
  - Never both high; both low in IDLE/DEION.
- Asynchronous reset mid-pulse forces gates low immediately, with no deion phase.

Test Plan:
- Continuous buck: waveform=16'hA000, ton=50, toff=100, is_breakdown asserted at wait cycle 400 → state 01→02 (gate_buck held), 50 cycles in 02, discharge_done pulse, 100 cycles in 80, back to 01 with timer restarted at 0; pulse_count=1.
- Blanking: is_breakdown held high from WAIT entry → no transition until timer=301, then 01→02.
- Single resistor: waveform=16'h6000, button pulse → 01 (gate_res=1); breakdown → 04 for ton; then 00 directly, gates low; a second button pulse restarts the sequence.
- Timeout: WAIT_TIMEOUT=1000, no breakdown → no_breakdown pulse at wait cycle 999, DEION for toff, WAIT again; pulse_count unchanged. Breakdown coincident with cycle 999 → discharge taken, no no_breakdown pulse.
- Edge durations: ton=0, toff=0 → each state lasts exactly 1 cycle. bit13 cleared mid-discharge → 80 then 00, no count.
- rst_n low mid-discharge → all outputs zero asynchronously; after release state=00, timer=0.
